// File: rtl/fast_accel_frame_sequencer.sv
// Runs a programmed number of fast_accel frames over ap_ctrl_hs, with a progress watchdog and abort.
// Optional perf counters are compiled in when FAST_SEQ_PERF_EN is defined.
module fast_accel_frame_sequencer #(
    parameter int FRAME_W = 16,
    parameter int TMO_W   = 24
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               cfg_start,
    input  logic [FRAME_W-1:0] cfg_num_frames,
    input  logic [TMO_W-1:0]   cfg_timeout,
    input  logic               cfg_abort,
    output logic               k_ap_start,
    input  logic               k_ap_ready,
    input  logic               k_ap_done,
    input  logic               k_ap_idle,
    input  logic               in_tvalid,
    input  logic               in_tready,
    input  logic               out_tvalid,
    input  logic               out_tready,
    output logic               busy,
    output logic               run_done,
    output logic [1:0]         status,
    output logic [FRAME_W-1:0] frames_done,
    output logic [31:0]        perf_busy_cycles,
    output logic [31:0]        perf_stall_cycles
);

    // Kernel handshake: k_ap_start is held until the cycle k_ap_ready is seen, then drops.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_ABORT   = 2'd2;

    state_t             state;
    logic [FRAME_W-1:0] num_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [TMO_W-1:0]   wdog;

    logic               accept;
    logic               progress;
    logic               done_take;
    logic               tmo_hit;
    logic [FRAME_W-1:0] frames_inc;
    logic [TMO_W-1:0]   wdog_inc;

    assign accept   = (state == S_IDLE) && cfg_start;
    assign progress = (in_tvalid & in_tready) | (out_tvalid & out_tready) | k_ap_done;

    // A done in LAUNCH only counts when it arrives together with ready.
    assign done_take = k_ap_done &&
                       ((state == S_RUN) || ((state == S_LAUNCH) && k_ap_ready));

    assign frames_inc = (frames_done == {FRAME_W{1'b1}}) ? frames_done
                                                         : frames_done + FRAME_W'(1);
    assign wdog_inc   = (wdog == tmo_q) ? wdog : wdog + TMO_W'(1);
    assign tmo_hit    = (tmo_q != '0) && !progress && (wdog_inc == tmo_q);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= S_IDLE;
            k_ap_start  <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            status      <= ST_OK;
            frames_done <= '0;
            num_q       <= '0;
            tmo_q       <= '0;
            wdog        <= '0;
        end else begin
            run_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        num_q       <= cfg_num_frames;
                        tmo_q       <= cfg_timeout;
                        frames_done <= '0;
                        status      <= ST_OK;
                        wdog        <= '0;
                        busy        <= 1'b1;
                        if (cfg_num_frames == '0) begin
                            state <= S_FINISH;
                        end else begin
                            state      <= S_LAUNCH;
                            k_ap_start <= 1'b1;
                        end
                    end
                end
                S_LAUNCH, S_RUN: begin
                    // Priority: abort, then a counted frame, then watchdog expiry.
                    if (cfg_abort) begin
                        k_ap_start <= 1'b0;
                        status     <= ST_ABORT;
                        state      <= S_DRAIN;
                    end else if (done_take) begin
                        frames_done <= frames_inc;
                        wdog        <= '0;
                        if (frames_inc == num_q) begin
                            state      <= S_FINISH;
                            k_ap_start <= 1'b0;
                        end else begin
                            state      <= S_LAUNCH;
                            k_ap_start <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        status     <= ST_TIMEOUT;
                        k_ap_start <= 1'b0;
                        wdog       <= wdog_inc;
                        state      <= S_DRAIN;
                    end else begin
                        wdog <= progress ? '0 : wdog_inc;
                        if ((state == S_LAUNCH) && k_ap_ready) begin
                            state      <= S_RUN;
                            k_ap_start <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (k_ap_idle) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    run_done <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FAST_SEQ_PERF_EN
    logic stall_now;
    assign stall_now = (in_tvalid & ~in_tready) | (out_tvalid & ~out_tready);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if (accept) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if (busy) begin
            if (perf_busy_cycles != 32'hFFFF_FFFF) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (stall_now && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`else
    assign perf_busy_cycles  = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fast_accel_frame_sequencer.sv
// Bench for fast_accel_frame_sequencer: directed scenario table, random runs, reset mid-run.
module tb_fast_accel_frame_sequencer;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        cfg_start;
    logic [15:0] cfg_num_frames;
    logic [23:0] cfg_timeout;
    logic        cfg_abort;
    logic        k_ap_start;
    logic        k_ap_ready;
    logic        k_ap_done;
    logic        k_ap_idle;
    logic        in_tvalid;
    logic        in_tready;
    logic        out_tvalid;
    logic        out_tready;
    logic        busy;
    logic        run_done;
    logic [1:0]  status;
    logic [15:0] frames_done;
    logic [31:0] perf_busy_cycles;
    logic [31:0] perf_stall_cycles;

    fast_accel_frame_sequencer #(.FRAME_W(16), .TMO_W(24)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cfg_start(cfg_start), .cfg_num_frames(cfg_num_frames),
        .cfg_timeout(cfg_timeout), .cfg_abort(cfg_abort),
        .k_ap_start(k_ap_start), .k_ap_ready(k_ap_ready),
        .k_ap_done(k_ap_done), .k_ap_idle(k_ap_idle),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .busy(busy), .run_done(run_done), .status(status),
        .frames_done(frames_done),
        .perf_busy_cycles(perf_busy_cycles),
        .perf_stall_cycles(perf_stall_cycles)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scenario knobs and a small reactive kernel model.
    int v_rdy, v_dn, v_stall, v_abrt;
    int k_st, k_cnt, k_hang_cnt, k_completed, k_readies;
    bit k_hung, k_hang_used;

    // Reference model of the run, in terms of run phases.
    bit     m_busy, m_start, m_wait, m_drain, m_wrap, m_run_done;
    int     m_status, m_frames, m_target, m_limit, m_quiet;
    longint m_pb, m_ps;

    int edge_count, accept_edge, last_prog_edge, tmo_edge, done_edge;

    task automatic kernel_reset();
        k_st = 0; k_cnt = 0; k_hang_cnt = 0; k_completed = 0;
        k_readies = 0; k_hung = 0; k_hang_used = 0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_start = 0; m_wait = 0; m_drain = 0; m_wrap = 0;
        m_run_done = 0; m_status = 0; m_frames = 0; m_target = 0;
        m_limit = 0; m_quiet = 0; m_pb = 0; m_ps = 0;
    endtask

    task automatic drive_kernel();
        k_ap_ready = 0; k_ap_done = 0; cfg_abort = 0;
        if (k_hung) begin
            k_hang_cnt++;
            if (k_hang_cnt >= 40) begin
                k_hung = 0;
                k_hang_used = 1;
            end
        end else if (k_st == 0 && k_ap_start === 1'b1) begin
            if (k_completed == v_stall && !k_hang_used) begin
                k_hung = 1;
                k_hang_cnt = 0;
            end else begin
                k_st = 1;
                k_cnt = 0;
            end
        end
        if (k_st == 1) begin
            if (k_cnt >= v_rdy) begin
                k_ap_ready = 1; k_readies++; k_st = 2; k_cnt = 0;
                if (v_dn == 0) begin
                    k_ap_done = 1; k_st = 0; k_completed++;
                end
            end else begin
                k_cnt++;
            end
        end else if (k_st == 2) begin
            k_cnt++;
            if (k_cnt >= v_dn) begin
                k_ap_done = 1; k_st = 0; k_completed++;
            end else if (k_completed == v_abrt && k_cnt == 3) begin
                cfg_abort = 1;
            end
        end
        k_ap_idle = (k_st == 0) && !k_hung;
        if (k_st == 2) begin
            in_tvalid  = 1'($urandom_range(0, 1));
            in_tready  = 1'($urandom_range(0, 1));
            out_tvalid = 1'($urandom_range(0, 1));
            out_tready = 1'($urandom_range(0, 1));
        end else begin
            in_tvalid = 0; in_tready = 0; out_tvalid = 0; out_tready = 0;
        end
    endtask

    task automatic model_edge();
        automatic bit prog = (in_tvalid && in_tready) || (out_tvalid && out_tready) || k_ap_done;
        automatic bit stl  = (in_tvalid && !in_tready) || (out_tvalid && !out_tready);
        automatic bit counted;
        if (m_busy) begin
            m_pb++;
            if (stl) m_ps++;
        end
        m_run_done = 0;
        if (!m_busy) begin
            if (cfg_start) begin
                m_busy = 1; m_frames = 0; m_status = 0; m_quiet = 0;
                m_target = int'(cfg_num_frames); m_limit = int'(cfg_timeout);
                m_pb = 0; m_ps = 0;
                if (m_target == 0) m_wrap = 1;
                else m_start = 1;
            end
        end else if (m_wrap) begin
            m_wrap = 0; m_busy = 0; m_run_done = 1;
        end else if (m_drain) begin
            if (k_ap_idle) begin
                m_drain = 0; m_wrap = 1;
            end
        end else begin
            counted = k_ap_done && (m_wait || (m_start && k_ap_ready));
            if (cfg_abort) begin
                m_start = 0; m_wait = 0; m_status = 2; m_drain = 1;
            end else if (counted) begin
                m_frames = (m_frames == 65535) ? 65535 : m_frames + 1;
                m_quiet = 0; m_wait = 0;
                if (m_frames == m_target) begin
                    m_wrap = 1; m_start = 0;
                end else begin
                    m_start = 1;
                end
            end else if (m_limit != 0 && !prog && m_quiet + 1 >= m_limit) begin
                m_status = 1; m_start = 0; m_wait = 0; m_drain = 1;
            end else begin
                m_quiet = prog ? 0 : m_quiet + 1;
                if (m_start && k_ap_ready) begin
                    m_start = 0; m_wait = 1;
                end
            end
        end
    endtask

    task automatic compare_model();
        chk("k_ap_start", 32'(k_ap_start), 32'(m_start));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("run_done", 32'(run_done), 32'(m_run_done));
        chk("status", 32'(status), 32'(m_status));
        chk("frames_done", 32'(frames_done), 32'(m_frames));
`ifdef FAST_SEQ_PERF_EN
        chk("perf_busy", perf_busy_cycles, 32'(m_pb));
        chk("perf_stall", perf_stall_cycles, 32'(m_ps));
`else
        chk("perf_busy_off", perf_busy_cycles, 32'd0);
        chk("perf_stall_off", perf_stall_cycles, 32'd0);
`endif
    endtask

    task automatic tick();
        drive_kernel();
        if (tmo_edge < 0 && ((in_tvalid && in_tready) || (out_tvalid && out_tready) || k_ap_done))
            last_prog_edge = edge_count + 1;
        model_edge();
        @(posedge ap_clk);
        #1;
        edge_count++;
        compare_model();
        if (tmo_edge < 0 && status == 2'd1) tmo_edge = edge_count;
        if (done_edge < 0 && run_done === 1'b1) done_edge = edge_count;
    endtask

    task automatic start_run(input int nf, input int tmo);
        k_completed = 0; k_hang_used = 0; k_readies = 0;
        cfg_num_frames = 16'(nf);
        cfg_timeout = 24'(tmo);
        cfg_start = 1;
        tmo_edge = -1; done_edge = -1;
        tick();
        cfg_start = 0;
        accept_edge = edge_count;
        last_prog_edge = edge_count;
    endtask

    task automatic finish_run();
        int n;
        n = 0;
        do begin
            if (n == 4 && m_busy) begin
                cfg_start = 1; cfg_num_frames = 16'd7; cfg_timeout = 24'd3;
            end
            tick();
            cfg_start = 0;
            n++;
        end while (!m_run_done && n < 3000);
        if (!m_run_done) begin
            checks++; errors++;
            $display("FAIL run_bound got=no_run_end expected=run_end");
        end
        repeat (2) tick();
    endtask

    typedef struct {
        int nf; int tmo; int rdy; int dn; int stall; int abrt;
        int exp_frames; int exp_status; int exp_starts;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{nf: 3, tmo: 1000, rdy: 2, dn: 50, stall: -1, abrt: -1, exp_frames: 3, exp_status: 0, exp_starts: 3};
        tbl[1] = '{nf: 0, tmo: 1000, rdy: 2, dn: 50, stall: -1, abrt: -1, exp_frames: 0, exp_status: 0, exp_starts: 0};
        tbl[2] = '{nf: 4, tmo: 20, rdy: 2, dn: 10, stall: 1, abrt: -1, exp_frames: 1, exp_status: 1, exp_starts: 1};
        tbl[3] = '{nf: 4, tmo: 1000, rdy: 2, dn: 10, stall: -1, abrt: 1, exp_frames: 1, exp_status: 2, exp_starts: 2};
        tbl[4] = '{nf: 2, tmo: 100, rdy: 2, dn: 0, stall: -1, abrt: -1, exp_frames: 2, exp_status: 0, exp_starts: 2};

        ap_rst_n = 0; cfg_start = 0; cfg_num_frames = 0; cfg_timeout = 0; cfg_abort = 0;
        k_ap_ready = 0; k_ap_done = 0; k_ap_idle = 1;
        in_tvalid = 0; in_tready = 0; out_tvalid = 0; out_tready = 0;
        edge_count = 0; tmo_edge = -1; done_edge = -1;
        kernel_reset();
        model_reset();
        repeat (3) @(posedge ap_clk);
        #1;
        chk("reset_start", 32'(k_ap_start), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_run_done", 32'(run_done), 32'd0);
        chk("reset_status", 32'(status), 32'd0);
        chk("reset_frames", 32'(frames_done), 32'd0);
        chk("reset_perf_busy", perf_busy_cycles, 32'd0);
        chk("reset_perf_stall", perf_stall_cycles, 32'd0);
        ap_rst_n = 1;
        tick();

        for (int i = 0; i < 5; i++) begin
            v_rdy = tbl[i].rdy; v_dn = tbl[i].dn; v_stall = tbl[i].stall; v_abrt = tbl[i].abrt;
            start_run(tbl[i].nf, tbl[i].tmo);
            finish_run();
            chk($sformatf("vec%0d_frames", i), 32'(frames_done), 32'(tbl[i].exp_frames));
            chk($sformatf("vec%0d_status", i), 32'(status), 32'(tbl[i].exp_status));
            chk($sformatf("vec%0d_starts", i), 32'(k_readies), 32'(tbl[i].exp_starts));
            if (tbl[i].nf == 0)
                chk("zero_frame_latency", 32'(done_edge - accept_edge), 32'd1);
            if (tbl[i].exp_status == 1)
                chk("timeout_gap", 32'(tmo_edge - last_prog_edge), 32'(tbl[i].tmo));
        end

        for (int r = 0; r < 24; r++) begin
            automatic int nf = $urandom_range(0, 4);
            automatic int tmo = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(6, 60);
            v_rdy = $urandom_range(0, 4);
            v_dn = $urandom_range(0, 30);
            v_stall = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            v_abrt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            start_run(nf, tmo);
            finish_run();
        end

        // Reset in the middle of a run, then a fresh single-frame run.
        v_rdy = 2; v_dn = 30; v_stall = -1; v_abrt = -1;
        start_run(2, 500);
        repeat (10) tick();
        #3;
        ap_rst_n = 0;
        #1;
        chk("midrst_start", 32'(k_ap_start), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_run_done", 32'(run_done), 32'd0);
        chk("midrst_status", 32'(status), 32'd0);
        chk("midrst_frames", 32'(frames_done), 32'd0);
        chk("midrst_perf_busy", perf_busy_cycles, 32'd0);
        kernel_reset();
        model_reset();
        in_tvalid = 0; in_tready = 0; out_tvalid = 0; out_tready = 0;
        k_ap_ready = 0; k_ap_done = 0; k_ap_idle = 1;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1;
        tick();
        v_rdy = 1; v_dn = 12;
        start_run(1, 500);
        finish_run();
        chk("post_reset_frames", 32'(frames_done), 32'd1);
        chk("post_reset_status", 32'(status), 32'd0);
`ifdef FAST_SEQ_PERF_EN
        chk("post_reset_perf_busy", perf_busy_cycles, 32'(done_edge - accept_edge));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fast_accel_frame_sequencer.md
Name: fast_accel_frame_sequencer

Overview:
Sequencer that drives the fast_accel kernel's ap_ctrl_hs handshake to run a programmed number of frames back to back. It watches the img_in/img_out AXI-Stream handshakes and ap_done to detect forward progress. A programmable watchdog turns a stalled kernel into a reported timeout instead of a silent hang. It sits between the host-side control registers and the fast_accel top, in the same clock domain.

Parameters:
FRAME_W, 16, width of frame count and frames_done counter
TMO_W, 24, width of watchdog timeout value and counter

Ports:
ap_clk  in  1  kernel clock, all logic rising-edge
ap_rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse, launches a run; ignored unless state is IDLE
cfg_num_frames  in  FRAME_W  frames to run, sampled on accepted cfg_start
cfg_timeout  in  TMO_W  watchdog limit in cycles, sampled on accepted cfg_start; 0 disables watchdog
cfg_abort  in  1  level, requests early termination
k_ap_start  out  1  to kernel ap_start
k_ap_ready  in  1  kernel ap_ready
k_ap_done  in  1  kernel ap_done
k_ap_idle  in  1  kernel ap_idle
in_tvalid, in_tready  in  1 each  img_in stream handshake (monitor only)
out_tvalid, out_tready  in  1 each  img_out stream handshake (monitor only)
busy  out  1  high from accepted cfg_start until run end
run_done  out  1  one-cycle pulse at run end
status  out  2  0=ok, 1=timeout, 2=aborted; held until next accepted cfg_start
frames_done  out  FRAME_W  frames completed in current/last run
perf_busy_cycles  out  32  see Optional Feature
perf_stall_cycles  out  32  see Optional Feature

Behaviour:
- Reset (async assert, sync release): state IDLE; k_ap_start=0, busy=0, run_done=0, status=0, frames_done=0, watchdog=0, perf counters=0.
- States: IDLE, LAUNCH, RUN, DRAIN, FINISH.
- IDLE: cfg_start=1 → latch num_frames/timeout, clear frames_done, status, watchdog; busy=1 next cycle. If cfg_num_frames=0 → FINISH directly; k_ap_start never asserted. Otherwise → LAUNCH.
- LAUNCH: k_ap_start=1, held until k_ap_ready=1. Move to RUN on the ready cycle; k_ap_start drops the following cycle.
- RUN: k_ap_done=1 → frames_done+1. If frames_done+1 == num_frames → FINISH, status ok. Otherwise → LAUNCH.
- k_ap_done may arrive in the same cycle as k_ap_ready while in LAUNCH. It counts exactly once and follows the RUN rules in that cycle.
- Progress event: (in_tvalid&in_tready) | (out_tvalid&out_tready) | k_ap_done. Watchdog clears on a progress event, otherwise increments while in LAUNCH/RUN.
- Watchdog = cfg_timeout (non-zero) → status=1, k_ap_start=0, → DRAIN. A progress event in the same cycle wins: no timeout.
- cfg_abort=1 in LAUNCH/RUN → k_ap_start=0 next cycle, status=2, → DRAIN. Abort takes priority over timeout in the same cycle. Abort is ignored in IDLE/DRAIN/FINISH.
- DRAIN: wait for k_ap_idle=1, then → FINISH. No watchdog in DRAIN. k_ap_done here does not increment frames_done.
- FINISH: run_done=1 for exactly one cycle, busy=0 in the same cycle, → IDLE.
- frames_done saturates at all-ones and never wraps. The watchdog saturates at cfg_timeout.
- cfg_start while busy is ignored, with no side effects.

Optional Feature:
FAST_SEQ_PERF_EN
- Defined:
  - perf_busy_cycles counts cycles with busy=1.
  - perf_stall_cycles counts busy cycles with (in_tvalid&~in_tready) | (out_tvalid&~out_tready).
  - Both clear on accepted cfg_start, saturate at 2^32-1, and hold after the run.
- Undefined: both ports are constant 0 and no counter flops exist.

Test Plan:
- cfg_num_frames=3, timeout=1000, kernel model ready 2 cycles after start, done 50 cycles later → three k_ap_start/k_ap_ready pairs, frames_done=3, run_done pulse, status=0, busy low same cycle.
- cfg_num_frames=0 → k_ap_start never asserted; run_done 2 cycles after cfg_start, frames_done=0, status=0.
- timeout=20, kernel stalls with no stream handshakes after frame 1 → status=1 exactly 20 idle cycles after the last progress event; DRAIN until k_ap_idle, then run_done; frames_done=1.
- cfg_abort asserted mid-frame 2 of 4, with ap_done later in DRAIN → status=2, frames_done=1, run_done only after k_ap_idle=1.
- k_ap_ready and k_ap_done in the same cycle, num_frames=2 → each frame counted once, frames_done=2; cfg_start pulsed while busy has no effect.
- ap_rst_n asserted mid-RUN → all outputs at reset values immediately; after release, a fresh run of 1 frame completes normally. With FAST_SEQ_PERF_EN, perf_busy_cycles equals the busy cycle count.
